// File: rtl/thermo_sequence_checker.sv
// -----------------------------------------------------------------------------
// thermo_sequence_checker
//
// Purpose:
//   Decodes 7-bit thermometer samples from a random generator. It locks onto
//   the generator's 3-bit LFSR-style sequence (1,4,6,7,3,5,2,...) and flags
//   illegal codes and out-of-sequence samples. Saturating counters record
//   correct predictions while locked and the total number of errors.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   in_valid    in   qualifies in_value for this cycle
//   in_value    in   7-bit thermometer code
//   dec_value   out  decoded ones count of last sample (0 when illegal)
//   dec_valid   out  one-cycle pulse: dec_value/code_err/seq_err updated
//   code_err    out  last sample was an illegal code
//   seq_err     out  last sample legal but mispredicted while locked
//   locked      out  FSM is in LOCKED
//   match_count out  saturating count of correct predictions while locked
//   err_count   out  saturating count of code_err + seq_err pulses
// -----------------------------------------------------------------------------
module thermo_sequence_checker #(
    parameter int LOCK_THRESH = 3,
    parameter int LOSS_THRESH = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [6:0]       in_value,
    output logic [2:0]       dec_value,
    output logic             dec_valid,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_T  = 4'(LOCK_THRESH);
    localparam logic [3:0]       LOSS_T  = 4'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Returns {legal, ones_count}; only the seven true thermometer codes are legal.
    function automatic logic [3:0] thermo_decode(input logic [6:0] code);
        logic [3:0] res;
        case (code)
            7'b0000001: res = {1'b1, 3'd1};
            7'b0000011: res = {1'b1, 3'd2};
            7'b0000111: res = {1'b1, 3'd3};
            7'b0001111: res = {1'b1, 3'd4};
            7'b0011111: res = {1'b1, 3'd5};
            7'b0111111: res = {1'b1, 3'd6};
            7'b1111111: res = {1'b1, 3'd7};
            default:    res = {1'b0, 3'd0};
        endcase
        return res;
    endfunction

    // Generator model: shift right, feeding p[2]^p[0] into the MSB.
    function automatic logic [2:0] pred_next(input logic [2:0] p);
        return {p[2] ^ p[0], p[2:1]};
    endfunction

    state_t           r_state;
    logic [2:0]       r_p;
    logic [3:0]       r_run;
    logic [3:0]       r_miss;
    logic [2:0]       r_dec_value;
    logic             r_dec_valid;
    logic             r_code_err;
    logic             r_seq_err;
    logic             r_locked;
    logic [CNT_W-1:0] r_match_count;
    logic [CNT_W-1:0] r_err_count;

    state_t           w_state_nxt;
    logic [2:0]       w_p_nxt;
    logic [3:0]       w_run_nxt;
    logic [3:0]       w_miss_nxt;
    logic [2:0]       w_dec_value_nxt;
    logic             w_dec_valid_nxt;
    logic             w_code_err_nxt;
    logic             w_seq_err_nxt;
    logic             w_match_inc;
    logic             w_err_inc;
    logic [3:0]       w_dec;
    logic             w_legal;
    logic [2:0]       w_val;

    assign w_dec   = thermo_decode(in_value);
    assign w_legal = w_dec[3];
    assign w_val   = w_dec[2:0];

    // Next-state, predictor and output-pulse logic for one accepted sample.
    always_comb begin
        w_state_nxt     = r_state;
        w_p_nxt         = r_p;
        w_run_nxt       = r_run;
        w_miss_nxt      = r_miss;
        w_dec_value_nxt = r_dec_value;
        w_dec_valid_nxt = 1'b0;
        w_code_err_nxt  = 1'b0;
        w_seq_err_nxt   = 1'b0;
        w_match_inc     = 1'b0;
        w_err_inc       = 1'b0;
        if (in_valid) begin
            w_dec_valid_nxt = 1'b1;
            w_dec_value_nxt = w_val;
            w_code_err_nxt  = ~w_legal;
            w_err_inc       = ~w_legal;
            case (r_state)
                ST_SEED: begin
                    if (w_legal) begin
                        w_p_nxt     = pred_next(w_val);
                        w_run_nxt   = 4'd0;
                        w_state_nxt = ST_ACQUIRE;
                    end else begin
                        w_state_nxt = ST_SEED;
                    end
                end
                ST_ACQUIRE: begin
                    if (!w_legal) begin
                        w_run_nxt   = 4'd0;
                        w_state_nxt = ST_SEED;
                    end else if (w_val == r_p) begin
                        w_p_nxt = pred_next(r_p);
                        if (r_run + 4'd1 == LOCK_T) begin
                            w_run_nxt   = 4'd0;
                            w_miss_nxt  = 4'd0;
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_run_nxt = r_run + 4'd1;
                        end
                    end else begin
                        // Mismatch while acquiring: treat this sample as a fresh seed.
                        w_p_nxt   = pred_next(w_val);
                        w_run_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // Locked predictor free-runs; no re-seeding from the input.
                    w_p_nxt = pred_next(r_p);
                    if (w_legal && (w_val == r_p)) begin
                        w_match_inc = 1'b1;
                        w_miss_nxt  = 4'd0;
                    end else begin
                        w_seq_err_nxt = w_legal;
                        w_err_inc     = 1'b1;
                        if (r_miss + 4'd1 == LOSS_T) begin
                            w_miss_nxt  = 4'd0;
                            w_run_nxt   = 4'd0;
                            w_state_nxt = ST_SEED;
                        end else begin
                            w_miss_nxt = r_miss + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_SEED;
                    w_run_nxt   = 4'd0;
                    w_miss_nxt  = 4'd0;
                end
            endcase
        end else begin
            w_dec_valid_nxt = 1'b0;
        end
    end

    // State, predictor, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_SEED;
            r_p           <= 3'b001;
            r_run         <= 4'd0;
            r_miss        <= 4'd0;
            r_dec_value   <= 3'd0;
            r_dec_valid   <= 1'b0;
            r_code_err    <= 1'b0;
            r_seq_err     <= 1'b0;
            r_locked      <= 1'b0;
            r_match_count <= {CNT_W{1'b0}};
            r_err_count   <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_p         <= w_p_nxt;
            r_run       <= w_run_nxt;
            r_miss      <= w_miss_nxt;
            r_dec_value <= w_dec_value_nxt;
            r_dec_valid <= w_dec_valid_nxt;
            r_code_err  <= w_code_err_nxt;
            r_seq_err   <= w_seq_err_nxt;
            // Tracks the next state so locked changes with the sample's pulse.
            r_locked    <= (w_state_nxt == ST_LOCKED);
            if (w_match_inc && (r_match_count != CNT_MAX)) begin
                r_match_count <= r_match_count + CNT_ONE;
            end
            if (w_err_inc && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    assign dec_value   = r_dec_value;
    assign dec_valid   = r_dec_valid;
    assign code_err    = r_code_err;
    assign seq_err     = r_seq_err;
    assign locked      = r_locked;
    assign match_count = r_match_count;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_thermo_sequence_checker.sv
// Directed testbench for thermo_sequence_checker (default parameters).
module tb_thermo_sequence_checker;

    localparam logic [6:0] T1 = 7'b0000001;
    localparam logic [6:0] T2 = 7'b0000011;
    localparam logic [6:0] T3 = 7'b0000111;
    localparam logic [6:0] T4 = 7'b0001111;
    localparam logic [6:0] T5 = 7'b0011111;
    localparam logic [6:0] T6 = 7'b0111111;
    localparam logic [6:0] T7 = 7'b1111111;
    localparam logic [6:0] BAD = 7'b0000101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_value = 7'd0;
    logic [2:0] dec_value;
    logic       dec_valid;
    logic       code_err;
    logic       seq_err;
    logic       locked;
    logic [7:0] match_count;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    thermo_sequence_checker #(
        .LOCK_THRESH(3),
        .LOSS_THRESH(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_value(in_value),
        .dec_value(dec_value),
        .dec_valid(dec_valid),
        .code_err(code_err),
        .seq_err(seq_err),
        .locked(locked),
        .match_count(match_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Presents one sample for one cycle; returns just after the capturing edge.
    task automatic send(input logic [6:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({dec_value, dec_valid, code_err, seq_err, locked} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000000", {dec_value, dec_valid, code_err, seq_err, locked});
        end
        n_checks++;
        if ({match_count, err_count} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h want 0000", {match_count, err_count});
        end
    endtask

    task automatic test_acquire_lock();
        send(T1);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_value !== 3'd1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_sample: got valid=%b val=%0d lock=%b want 1/1/0", dec_valid, dec_value, locked);
        end
        send(T4);
        send(T6);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL early_lock: got %b want 0", locked);
        end
        send(T7);
        n_checks++;
        if (locked !== 1'b1 || dec_value !== 3'd7 || code_err !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL lock_after_4: got lock=%b val=%0d cerr=%b errs=%0d want 1/7/0/0", locked, dec_value, code_err, err_count);
        end
    endtask

    task automatic test_match_wrap();
        logic [6:0] seq [7];
        seq = '{T3, T5, T2, T1, T4, T6, T7};
        for (int i = 0; i < 7; i++) begin
            send(seq[i]);
            n_checks++;
            if (seq_err !== 1'b0 || code_err !== 1'b0 || locked !== 1'b1 || match_count !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL match_step%0d: got serr=%b cerr=%b lock=%b mc=%0d want 0/0/1/%0d", i, seq_err, code_err, locked, match_count, i + 1);
            end
        end
        n_checks++;
        if (err_count !== 8'd0 || dec_value !== 3'd7) begin
            n_fail++;
            $display("FAIL after_wrap: got errs=%0d val=%0d want 0/7", err_count, dec_value);
        end
    endtask

    task automatic test_idle_gap();
        int bad;
        bad = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_value = T5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (dec_valid !== 1'b0 || code_err !== 1'b0 || seq_err !== 1'b0 || locked !== 1'b1 || match_count !== 8'd7) begin
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d bad cycles want 0", bad);
        end
        send(T3);
        n_checks++;
        if (seq_err !== 1'b0 || match_count !== 8'd8 || dec_value !== 3'd3) begin
            n_fail++;
            $display("FAIL idle_resume: got serr=%b mc=%0d val=%0d want 0/8/3", seq_err, match_count, dec_value);
        end
    endtask

    task automatic test_code_and_seq_err();
        send(BAD);
        n_checks++;
        if (code_err !== 1'b1 || seq_err !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1 || dec_value !== 3'd0) begin
            n_fail++;
            $display("FAIL code_err_locked: got cerr=%b serr=%b errs=%0d lock=%b val=%0d want 1/0/1/1/0", code_err, seq_err, err_count, locked, dec_value);
        end
        send(T7);
        n_checks++;
        if (seq_err !== 1'b1 || code_err !== 1'b0 || locked !== 1'b0 || err_count !== 8'd2 || match_count !== 8'd8) begin
            n_fail++;
            $display("FAIL seq_err_unlock: got serr=%b cerr=%b lock=%b errs=%0d mc=%0d want 1/0/0/2/8", seq_err, code_err, locked, err_count, match_count);
        end
    endtask

    task automatic test_reseed();
        do_reset();
        send(T1);
        send(T4);
        send(T3);
        n_checks++;
        if (locked !== 1'b0 || seq_err !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reseed_on_3: got lock=%b serr=%b errs=%0d want 0/0/0", locked, seq_err, err_count);
        end
        send(T5);
        send(T2);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reseed_early: got %b want 0", locked);
        end
        send(T1);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL reseed_lock: got %b want 1", locked);
        end
        // Reset while locked (p expects 4): 4 must seed, not count as a match.
        do_reset();
        send(T4);
        n_checks++;
        if (locked !== 1'b0 || match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_history: got lock=%b mc=%0d want 0/0", locked, match_count);
        end
        send(T6);
        send(T7);
        send(T3);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_from_4: got %b want 1", locked);
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        for (int i = 0; i < 255; i++) begin
            send(BAD);
        end
        n_checks++;
        if (err_count !== 8'd255 || code_err !== 1'b1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reach_255: got errs=%0d cerr=%b lock=%b want 255/1/0", err_count, code_err, locked);
        end
        send(7'd0);
        send(BAD);
        n_checks++;
        if (err_count !== 8'd255 || code_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_saturate: got errs=%0d cerr=%b want 255/1", err_count, code_err);
        end
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_value = T1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({dec_value, dec_valid, code_err, seq_err, locked, match_count, err_count} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_over_valid: got %h want 0", {dec_value, dec_valid, code_err, seq_err, locked, match_count, err_count});
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acquire_lock();
        test_match_wrap();
        test_idle_gap();
        test_code_and_seq_err();
        test_reseed();
        test_err_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
